// File: rtl/sram_pkg.sv
// Shared definitions for the 8-block SRAM.
// Contents: default geometry (DATA_W, ADDR_W, NBLK), the derived widths, and the
// word, per-block address, combined address and block-select types.
package sram_pkg;

  localparam int unsigned DATA_W  = 20;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned NBLK    = 8;
  localparam int unsigned BSEL_W  = $clog2(NBLK);
  localparam int unsigned CADDR_W = ADDR_W + BSEL_W;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [CADDR_W-1:0] caddr_t;
  typedef logic [BSEL_W-1:0]  bsel_t;

  // Block number carried in the top bits of a combined address.
  function automatic bsel_t blk_of(caddr_t ca);
    return ca[CADDR_W-1 -: BSEL_W];
  endfunction

endpackage

// File: rtl/sram_blk.sv
// One SRAM block: 2**AddrBits words of Width bits, one write port and one
// registered read port.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset; clears q only, never the array
//   we     - write strobe for this block (already decoded)
//   re     - read strobe
//   waddr  - write word address
//   wdata  - write data
//   raddr  - read word address
//   q      - registered read data, holds between reads
module sram_blk
  import sram_pkg::*;
#(
  parameter int unsigned Width    = DATA_W,
  parameter int unsigned AddrBits = ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                re,
  input  logic [AddrBits-1:0] waddr,
  input  logic [Width-1:0]    wdata,
  input  logic [AddrBits-1:0] raddr,
  output logic [Width-1:0]    q
);

  localparam int unsigned Depth = 2 ** AddrBits;

  logic [Width-1:0] mem [Depth];

  // The array shares the reset-sensitive process so that an access seen while
  // rst_n is low is dropped, yet the reset branch leaves the contents alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        q <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/sram_8blk.sv
// Eight independent SRAM blocks behind a shared write port and eight
// parallel read ports.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset, clears Q0..Q7
//   sclk     - reserved input, not used by the logic
//   CEN      - chip enable, active-low
//   WEN      - write enable, active-low (1 = read)
//   CADDR    - write address: top 3 bits pick the block, low ADDR_W bits the word
//   D        - write data
//   A0..A7   - read address of block 0..7
//   Q0..Q7   - registered read data of block 0..7
module sram_8blk
  import sram_pkg::bsel_t;
#(
  parameter int unsigned DATA_W = sram_pkg::DATA_W,
  parameter int unsigned ADDR_W = sram_pkg::ADDR_W,
  parameter int unsigned NBLK   = sram_pkg::NBLK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [ADDR_W+2:0] CADDR,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] A0,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [ADDR_W-1:0] A4,
  input  logic [ADDR_W-1:0] A5,
  input  logic [ADDR_W-1:0] A6,
  input  logic [ADDR_W-1:0] A7,
  output logic [DATA_W-1:0] Q0,
  output logic [DATA_W-1:0] Q1,
  output logic [DATA_W-1:0] Q2,
  output logic [DATA_W-1:0] Q3,
  output logic [DATA_W-1:0] Q4,
  output logic [DATA_W-1:0] Q5,
  output logic [DATA_W-1:0] Q6,
  output logic [DATA_W-1:0] Q7
);

  logic rd_en;
  logic wr_en;
  logic unused_sclk;

  logic [ADDR_W-1:0] a_arr [NBLK];
  logic [DATA_W-1:0] q_arr [NBLK];

  assign unused_sclk = sclk;

  assign rd_en = ~CEN & WEN;
  assign wr_en = ~CEN & ~WEN;

  assign a_arr[0] = A0;
  assign a_arr[1] = A1;
  assign a_arr[2] = A2;
  assign a_arr[3] = A3;
  assign a_arr[4] = A4;
  assign a_arr[5] = A5;
  assign a_arr[6] = A6;
  assign a_arr[7] = A7;

  assign Q0 = q_arr[0];
  assign Q1 = q_arr[1];
  assign Q2 = q_arr[2];
  assign Q3 = q_arr[3];
  assign Q4 = q_arr[4];
  assign Q5 = q_arr[5];
  assign Q6 = q_arr[6];
  assign Q7 = q_arr[7];

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic blk_we;

    assign blk_we = wr_en & (CADDR[ADDR_W +: 3] == bsel_t'(k));

    sram_blk #(
      .Width    (DATA_W),
      .AddrBits (ADDR_W)
    ) u_blk (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (blk_we),
      .re    (rd_en),
      .waddr (CADDR[ADDR_W-1:0]),
      .wdata (D),
      .raddr (a_arr[k]),
      .q     (q_arr[k])
    );
  end

endmodule

// File: tb/tb_sram_8blk.sv
// Self-checking bench for sram_8blk: reset, full fill/readback, a vector table
// for block isolation, CEN gating and read-after-write, and a reset-mid-read
// sequence. A behavioural memory model feeds a scoreboard of expected Q values.
module tb_sram_8blk;
  import sram_pkg::*;

  typedef logic [NBLK-1:0][DATA_W-1:0] qvec_t;

  typedef struct {
    logic   cen;
    logic   wen;
    caddr_t caddr;
    word_t  d;
    addr_t  a;
    bsel_t  blk;
    word_t  exp;
  } vec_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  logic   sclk  = 1'b0;
  logic   cen   = 1'b1;
  logic   wen   = 1'b1;
  caddr_t caddr = '0;
  word_t  d     = '0;
  addr_t  a [NBLK];
  word_t  q [NBLK];

  word_t  mem_m [2 ** CADDR_W];
  qvec_t  q_m = '0;
  qvec_t  sb [$];
  vec_t   vt [15];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  sram_8blk u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (sclk),
    .CEN   (cen),
    .WEN   (wen),
    .CADDR (caddr),
    .D     (d),
    .A0    (a[0]),
    .A1    (a[1]),
    .A2    (a[2]),
    .A3    (a[3]),
    .A4    (a[4]),
    .A5    (a[5]),
    .A6    (a[6]),
    .A7    (a[7]),
    .Q0    (q[0]),
    .Q1    (q[1]),
    .Q2    (q[2]),
    .Q3    (q[3]),
    .Q4    (q[4]),
    .Q5    (q[5]),
    .Q6    (q[6]),
    .Q7    (q[7])
  );

  task automatic check(input string name, input word_t got, input word_t exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Drive one access and push the Q vector expected after the next edge.
  task automatic drive(input logic c, input logic w, input caddr_t ca, input word_t dd,
                       input addr_t aa);
    cen   = c;
    wen   = w;
    caddr = ca;
    d     = dd;
    for (int k = 0; k < NBLK; k++) a[k] = aa;
    sclk  = 1'($urandom_range(0, 1));
    if (rst_n && !c) begin
      if (!w) mem_m[ca] = dd;
      else for (int k = 0; k < NBLK; k++) q_m[k] = mem_m[{bsel_t'(k), aa}];
    end
    sb.push_back(q_m);
  endtask

  task automatic compare(input string name);
    qvec_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk_cnt++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", name);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k < NBLK; k++) check($sformatf("%s q%0d", name, k), q[k], e[k]);
  endtask

  initial begin
    for (int k = 0; k < NBLK; k++) a[k] = '0;

    // Cycle:            cen   wen   caddr    d         a      blk   exp
    vt[0]  = '{1'b0, 1'b1, 11'h000, 20'h00000, 8'h05, 3'd3, 20'h00005};
    vt[1]  = '{1'b0, 1'b0, 11'h305, 20'hABCDE, 8'h3C, 3'd3, 20'h00005};
    vt[2]  = '{1'b0, 1'b1, 11'h000, 20'h00000, 8'h05, 3'd3, 20'hABCDE};
    vt[3]  = '{1'b0, 1'b1, 11'h000, 20'h00000, 8'h07, 3'd0, 20'h00007};
    vt[4]  = '{1'b1, 1'b0, 11'h007, 20'hFFFFF, 8'h00, 3'd0, 20'h00007};
    vt[5]  = '{1'b1, 1'b1, 11'h000, 20'h00000, 8'h09, 3'd0, 20'h00007};
    vt[6]  = '{1'b0, 1'b1, 11'h000, 20'h00000, 8'h00, 3'd0, 20'h00000};
    vt[7]  = '{1'b0, 1'b1, 11'h000, 20'h00000, 8'h07, 3'd0, 20'h00007};
    vt[8]  = '{1'b0, 1'b0, 11'h7FF, 20'h12345, 8'hA5, 3'd7, 20'h00007};
    vt[9]  = '{1'b0, 1'b1, 11'h000, 20'h00000, 8'hFF, 3'd7, 20'h12345};
    vt[10] = '{1'b0, 1'b0, 11'h000, 20'h54321, 8'h11, 3'd7, 20'h12345};
    vt[11] = '{1'b0, 1'b1, 11'h000, 20'h00000, 8'h00, 3'd0, 20'h54321};
    vt[12] = '{1'b0, 1'b0, 11'h000, 20'h11111, 8'h22, 3'd0, 20'h54321};
    vt[13] = '{1'b0, 1'b1, 11'h000, 20'h00000, 8'h00, 3'd0, 20'h11111};
    vt[14] = '{1'b0, 1'b1, 11'h000, 20'h00000, 8'hFF, 3'd6, 20'h000FF};

    // Reset: Q must be zero while held and after release before any access.
    #12;
    for (int k = 0; k < NBLK; k++) check($sformatf("in_rst q%0d", k), q[k], '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, '0, '0, '0);
    compare("post_rst");

    // Fill every word with its low address byte, then read all blocks in parallel.
    for (int i = 0; i < 2 ** CADDR_W; i++) begin
      drive(1'b0, 1'b0, caddr_t'(i), word_t'(i % 256), addr_t'($urandom_range(0, 255)));
      compare("fill_wr");
    end
    for (int j = 0; j < 2 ** ADDR_W; j++) begin
      drive(1'b0, 1'b1, caddr_t'($urandom_range(0, 2047)), word_t'($urandom), addr_t'(j));
      compare("fill_rd");
      check("fill_rd_q5", q[5], word_t'(j));
    end

    // Isolation, CEN gating and read-after-write.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].cen, vt[i].wen, vt[i].caddr, vt[i].d, vt[i].a);
      compare($sformatf("vec%0d", i));
      check($sformatf("vec%0d blk%0d", i, vt[i].blk), q[vt[i].blk], vt[i].exp);
    end

    // Reset pulse between edges while Q holds data; contents must survive.
    check("pre_rst q7", q[7], 20'h12345);
    #2;
    rst_n = 1'b0;
    q_m   = '0;
    #1;
    for (int k = 0; k < NBLK; k++) check($sformatf("async_rst q%0d", k), q[k], '0);
    drive(1'b0, 1'b0, 11'h0AA, 20'hFFFFF, 8'h00);
    compare("wr_in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, '0, '0, 8'hAA);
    compare("idle_after_rst");
    drive(1'b0, 1'b1, '0, '0, 8'hAA);
    compare("rd_after_rst");
    check("rd_after_rst blk0", q[0], 20'h000AA);
    drive(1'b0, 1'b1, '0, '0, 8'hFF);
    compare("rd_kept");
    check("rd_kept blk7", q[7], 20'h12345);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sram_8blk.md
SRAM_8BLK -- requirements
Module: sram_8blk

Interface
- REQ-001 Parameter DATA_W, default 20: word width of every block.
- REQ-002 Parameter ADDR_W, default 8: per-block address width, giving 256 words per block.
- REQ-003 Parameter NBLK, default 8: number of blocks; CADDR width is ADDR_W+3.
- REQ-004 Port clk, input, 1: single system clock; all state changes on its rising edge.
- REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
- REQ-006 Port sclk, input, 1: reserved, not a clock; it SHALL be ignored by the logic.
- REQ-007 Port CEN, input, 1: chip enable, active-low.
- REQ-008 Port WEN, input, 1: write enable, active-low; 1 means read.
- REQ-009 Port CADDR, input, 11: write address; [10:8] selects the block, [7:0] selects the word.
- REQ-010 Port D, input, 20: write data.
- REQ-011 Ports A0..A7, input, 8 each: per-block read address; Ak addresses block k.
- REQ-012 Ports Q0..Q7, output, 20 each: registered read data of block k.

Function
- REQ-013 Storage SHALL be 8 independent blocks, each 256 x 20 bits, for 2048 words in total.
- REQ-014 On a clk rising edge with CEN=0 and WEN=0, the block selected by CADDR[10:8] SHALL store D at word CADDR[7:0]; no other word changes.
- REQ-015 During a write cycle, A0..A7 SHALL be ignored (they may be X/Z) and Q0..Q7 SHALL hold their previous values.
- REQ-016 On a clk rising edge with CEN=0 and WEN=1, every block k SHALL load its word at address Ak into Qk; all 8 reads happen in parallel.
- REQ-017 Read latency SHALL be one cycle: Qk is valid after the rising edge that samples Ak and holds until the next read edge or reset.
- REQ-018 During a read cycle, CADDR and D SHALL be ignored (they may be X/Z).
- REQ-019 With CEN=1, memory contents and Q0..Q7 SHALL be unchanged, whatever the other inputs are.
- REQ-020 Read and write SHALL be mutually exclusive because WEN is a single control signal; a read after a write to the same word SHALL return the new data.
- REQ-021 Reads of never-written words SHALL return an undefined value.
- REQ-022 Address behaviour has no wrap-around or out-of-range case: every CADDR value 0..2047 and every Ak value 0..255 is valid.

Reset
- REQ-023 While rst_n=0, Q0..Q7 SHALL be 0, forced asynchronously.
- REQ-024 Memory contents SHALL NOT be cleared by reset.
- REQ-025 An access presented while rst_n=0 SHALL have no effect.
- REQ-026 The first edge after rst_n rises SHALL operate normally.
- REQ-027 If reset is asserted in the middle of a read, Q SHALL show 0 until the next read.

Structure
- REQ-028 DATA_W, ADDR_W and NBLK, plus a data-word typedef and an address typedef, SHALL be defined in shared package sram_pkg.
- REQ-029 Each block SHALL be an instance of sub-module sram_blk: 256x20, single write port, registered read, with its own write enable decoded from CADDR[10:8].
- REQ-030 The top level SHALL contain only the block decode, the 8 instances and the output wiring.

Verification
- REQ-031 Reset with rst_n=0, then release; all Qk must read 0 before any access.
- REQ-032 Fill: with CEN=0 and WEN=0, write D=i%256 at CADDR=i for i=0..2047. Then with WEN=1, set all Ak=j for j=0..255; every Qk must equal j one cycle later.
- REQ-033 Block isolation: write 0xABCDE to CADDR=0x305 (block 3, word 5), then read all Ak=5. Q3 must be 0xABCDE and the other Qk must keep their prior values; Q must be unchanged on the write edge itself.
- REQ-034 CEN gating: read at address 7 so Q holds its value, then set CEN=1, WEN=0, CADDR=7, D=0xFFFFF. Memory must be unchanged, and a later read of address 7 must return the old value.
- REQ-035 Reset mid-read: after Q becomes nonzero, pulse rst_n low between edges. Q must go to 0 immediately, and a following read of the same addresses must return the stored data.
